// File: rtl/data_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_cache_pkg
// Description : Shared constants, FSM state encoding and byte-merge helper
//               for the direct-mapped write-back data cache.
// Revision    : 1.0 - initial release
// ============================================================================
package data_cache_pkg;

    localparam int LINE_BITS      = 128;
    localparam int OFFSET_BITS    = 4;
    localparam int WORDS_PER_LINE = 4;
    localparam int LINE_ADDR_W    = 32 - OFFSET_BITS;

    typedef enum logic [1:0] {
        ST_READY     = 2'd0,
        ST_WB_REQ    = 2'd1,
        ST_FILL_REQ  = 2'd2,
        ST_FILL_WAIT = 2'd3
    } state_t;

    // Replace the bytes of old_word selected by mask with those of new_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_cache_if.sv
`default_nettype none
// ============================================================================
// Module      : data_cache_if
// Description : Line-granular main-memory port of the data cache. The cache
//               is the master (issues requests), memory is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_cache_if;
    import data_cache_pkg::*;

    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic                   mem_req_rw;
    logic [LINE_ADDR_W-1:0] mem_req_addr;
    logic [LINE_BITS-1:0]   mem_req_data;
    logic                   mem_resp_valid;
    logic [LINE_BITS-1:0]   mem_resp_data;

    modport master (
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );

endinterface
`default_nettype wire

// File: rtl/data_cache_line_array.sv
`default_nettype none
// ============================================================================
// Module      : data_cache_line_array
// Description : Data, tag, valid and dirty storage for the data cache.
//               Combinational read by index, whole-line refill write and
//               byte-masked word write. Reset clears valid and dirty only.
// Revision    : 1.0 - initial release
// ============================================================================
module data_cache_line_array
    import data_cache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 24
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [IDX_W-1:0]                     idx,
    output logic [LINE_BITS-1:0]                 rd_line,
    output logic [TAG_W-1:0]                     rd_tag,
    output logic                                 rd_valid,
    output logic                                 rd_dirty,
    input  logic                                 line_we,
    input  logic [LINE_BITS-1:0]                 line_data,
    input  logic [TAG_W-1:0]                     line_tag,
    input  logic [3:0]                           word_mask,
    input  logic [$clog2(WORDS_PER_LINE)-1:0]    word_sel,
    input  logic [31:0]                          word_data
);

    logic [LINE_BITS-1:0] r_data [LINES];
    logic [TAG_W-1:0]     r_tag  [LINES];
    logic [LINES-1:0]     r_valid;
    logic [LINES-1:0]     r_dirty;

    logic [31:0]          w_old_word;

    assign rd_line    = r_data[idx];
    assign rd_tag     = r_tag[idx];
    assign rd_valid   = r_valid[idx];
    assign rd_dirty   = r_dirty[idx];
    assign w_old_word = rd_line[{word_sel, 5'b0} +: 32];

    // Line payload and tag storage; a refill wins over a store to the same line.
    always_ff @(posedge clk) begin
        if (line_we) begin
            r_data[idx] <= line_data;
            r_tag[idx]  <= line_tag;
        end else if (|word_mask) begin
            r_data[idx][{word_sel, 5'b0} +: 32] <= merge_bytes(w_old_word, word_data, word_mask);
        end
    end

    // Valid/dirty state: refill makes a line clean, a store makes it dirty.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (line_we) begin
            r_valid[idx] <= 1'b1;
            r_dirty[idx] <= 1'b0;
        end else if (|word_mask) begin
            r_dirty[idx] <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// Module      : data_cache
// Description : Direct-mapped, write-back, write-allocate data cache.
//               Hits complete the cycle after capture; misses stall while a
//               dirty victim is written back and the line is refilled, then
//               the held request completes as a hit.
// Revision    : 1.0 - initial release
// ============================================================================
module data_cache
    import data_cache_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dcache_addr,
    input  logic [31:0] dcache_din,
    input  logic        dcache_re,
    input  logic [3:0]  dcache_we,
    output logic [31:0] dcache_dout,
    output logic        stall,
    data_cache_if.master mem
);

    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = 32 - OFFSET_BITS - IDX_W;
    localparam int WSEL_W = $clog2(WORDS_PER_LINE);

    state_t                 r_state;
    logic                   r_pending;
    logic [31:2]            r_addr;
    logic [31:0]            r_din;
    logic [3:0]             r_mask;
    logic [31:0]            r_dout;
    logic                   r_req_valid;
    logic                   r_req_rw;
    logic [LINE_ADDR_W-1:0] r_req_addr;
    logic [LINE_BITS-1:0]   r_req_data;

    logic [IDX_W-1:0]       w_idx;
    logic [TAG_W-1:0]       w_tag;
    logic [WSEL_W-1:0]      w_word;
    logic [LINE_ADDR_W-1:0] w_line_addr;
    logic [LINE_BITS-1:0]   w_line;
    logic [TAG_W-1:0]       w_line_tag;
    logic                   w_line_valid;
    logic                   w_line_dirty;
    logic                   w_hit;
    logic                   w_active;
    logic                   w_is_store;
    logic                   w_rd_hit;
    logic                   w_st_hit;
    logic [31:0]            w_hit_word;
    logic                   w_new_req;
    logic                   w_fill;
    logic [3:0]             w_store_mask;
    logic [1:0]             w_unused_addr_lsb;

    // Byte offset within a word carries no information for aligned accesses.
    assign w_unused_addr_lsb = dcache_addr[1:0];

    assign w_idx       = r_addr[OFFSET_BITS+IDX_W-1:OFFSET_BITS];
    assign w_tag       = r_addr[31:OFFSET_BITS+IDX_W];
    assign w_word      = r_addr[OFFSET_BITS-1:2];
    assign w_line_addr = r_addr[31:OFFSET_BITS];

    assign w_hit      = w_line_valid && (w_line_tag == w_tag);
    assign w_is_store = |r_mask;
    assign w_active   = (r_state == ST_READY) && r_pending;
    assign w_rd_hit   = w_active && w_hit && !w_is_store;
    assign w_st_hit   = w_active && w_hit && w_is_store;
    assign w_hit_word = w_line[{w_word, 5'b0} +: 32];

    // A pending miss in READY stalls immediately, before the FSM moves on.
    assign stall     = (r_state != ST_READY) || (r_pending && !w_hit);
    assign w_new_req = dcache_re || (|dcache_we);

    // Read hits bypass straight from the array; otherwise hold the last read.
    assign dcache_dout = w_rd_hit ? w_hit_word : r_dout;

    assign w_fill       = (r_state == ST_FILL_WAIT) && mem.mem_resp_valid && !reset;
    assign w_store_mask = (w_st_hit && !reset) ? r_mask : 4'b0000;

    assign mem.mem_req_valid = r_req_valid;
    assign mem.mem_req_rw    = r_req_rw;
    assign mem.mem_req_addr  = r_req_addr;
    assign mem.mem_req_data  = r_req_data;

    data_cache_line_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_lines (
        .clk       (clk),
        .reset     (reset),
        .idx       (w_idx),
        .rd_line   (w_line),
        .rd_tag    (w_line_tag),
        .rd_valid  (w_line_valid),
        .rd_dirty  (w_line_dirty),
        .line_we   (w_fill),
        .line_data (mem.mem_resp_data),
        .line_tag  (w_tag),
        .word_mask (w_store_mask),
        .word_sel  (w_word),
        .word_data (r_din)
    );

    // Request latch, miss sequencing and registered memory-port outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_READY;
            r_pending   <= 1'b0;
            r_addr      <= '0;
            r_din       <= '0;
            r_mask      <= '0;
            r_dout      <= '0;
            r_req_valid <= 1'b0;
            r_req_rw    <= 1'b0;
            r_req_addr  <= '0;
            r_req_data  <= '0;
        end else begin
            case (r_state)
                ST_READY: begin
                    if (w_rd_hit) begin
                        r_dout <= w_hit_word;
                    end
                    if (!stall) begin
                        r_pending <= w_new_req;
                        if (w_new_req) begin
                            r_addr <= dcache_addr[31:2];
                            r_din  <= dcache_din;
                            r_mask <= dcache_we;
                        end
                    end else if (w_line_valid && w_line_dirty) begin
                        r_state     <= ST_WB_REQ;
                        r_req_valid <= 1'b1;
                        r_req_rw    <= 1'b1;
                        r_req_addr  <= {w_line_tag, w_idx};
                        r_req_data  <= w_line;
                    end else begin
                        r_state     <= ST_FILL_REQ;
                        r_req_valid <= 1'b1;
                        r_req_rw    <= 1'b0;
                        r_req_addr  <= w_line_addr;
                        r_req_data  <= '0;
                    end
                end
                ST_WB_REQ: begin
                    if (mem.mem_req_ready) begin
                        r_state    <= ST_FILL_REQ;
                        r_req_rw   <= 1'b0;
                        r_req_addr <= w_line_addr;
                        r_req_data <= '0;
                    end
                end
                ST_FILL_REQ: begin
                    if (mem.mem_req_ready) begin
                        r_state     <= ST_FILL_WAIT;
                        r_req_valid <= 1'b0;
                    end
                end
                ST_FILL_WAIT: begin
                    if (mem.mem_resp_valid) begin
                        r_state <= ST_READY;
                    end
                end
                default: begin
                    r_state <= ST_READY;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_cache
// Description : Self-checking bench for data_cache. A flat word-addressed
//               memory image holds the value every load must return; a
//               separate image models main memory behind the cache.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_cache;
    import data_cache_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] dcache_addr;
    logic [31:0] dcache_din;
    logic        dcache_re;
    logic [3:0]  dcache_we;
    logic [31:0] dcache_dout;
    logic        stall;

    data_cache_if mem_bus ();

    data_cache #(.LINES(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .dcache_addr (dcache_addr),
        .dcache_din  (dcache_din),
        .dcache_re   (dcache_re),
        .dcache_we   (dcache_we),
        .dcache_dout (dcache_dout),
        .stall       (stall),
        .mem         (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural view (what loads must see) and main-memory contents.
    logic [31:0] gold      [bit [29:0]];
    logic [31:0] mem_store [bit [29:0]];

    // Which line each index currently holds, per direct-mapped placement.
    bit          res_valid [16];
    bit [23:0]   res_tag   [16];
    bit          res_dirty [16];

    int mode_hold = -1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] req);
        n_checks++;
        if (obs !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, req);
        end
    endtask

    function automatic logic [31:0] init_word(input bit [29:0] k);
        return 32'h5A000000 ^ {2'b00, k};
    endfunction

    function automatic logic [31:0] gold_word(input bit [29:0] k);
        return gold.exists(k) ? gold[k] : init_word(k);
    endfunction

    function automatic logic [31:0] mem_word(input bit [29:0] k);
        return mem_store.exists(k) ? mem_store[k] : init_word(k);
    endfunction

    function automatic logic [127:0] gold_line(input bit [27:0] la);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) l[32*w +: 32] = gold_word({la, 2'(w)});
        return l;
    endfunction

    function automatic logic [127:0] mem_line(input bit [27:0] la);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) l[32*w +: 32] = mem_word({la, 2'(w)});
        return l;
    endfunction

    // One core access, entered and left at posedge+1. Services the memory
    // port while stalled and checks the outcome against the reference.
    task automatic access(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] we, input logic rd);
        bit [3:0]     idx       = a[7:4];
        bit [23:0]    tag       = a[31:8];
        bit [27:0]    la        = a[31:4];
        bit [29:0]    wa        = a[31:2];
        bit           is_store  = (we != 4'b0000);
        bit           exp_miss  = !(res_valid[idx] && res_tag[idx] == tag);
        bit           exp_wb    = exp_miss && res_dirty[idx];
        bit [27:0]    victim    = {res_tag[idx], idx};
        logic [31:0]  exp_rd    = gold_word(wa);
        logic [31:0]  nw;
        int           cycles    = 0;
        int           n_req     = 0;
        int           hold_cnt  = 0;
        int           resp_cnt  = 0;
        bit           req_open  = 0;
        bit           resp_wait = 0;
        bit           saw_wb    = 0;
        bit           hs;
        bit           give_resp;
        logic         req_rw0   = 1'b0;
        logic [27:0]  req_addr0 = '0;
        logic [127:0] req_data0 = '0;

        dcache_addr = a;
        dcache_din  = d;
        dcache_we   = we;
        dcache_re   = rd;
        @(posedge clk); #1;
        while (stall && cycles < 200) begin
            hs = 0;
            give_resp = 0;
            if (resp_wait) begin
                if (resp_cnt == 0) begin
                    mem_bus.mem_resp_valid = 1'b1;
                    mem_bus.mem_resp_data  = mem_line(la);
                    give_resp = 1;
                end else begin
                    resp_cnt--;
                end
            end else begin
                if (mode_hold < 0 && $urandom_range(0, 3) == 0) begin
                    mem_bus.mem_resp_valid = 1'b1;
                    mem_bus.mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
                end
                if (mem_bus.mem_req_valid) begin
                    if (!req_open) begin
                        req_open  = 1;
                        req_rw0   = mem_bus.mem_req_rw;
                        req_addr0 = mem_bus.mem_req_addr;
                        req_data0 = mem_bus.mem_req_data;
                        if (n_req == 0 && exp_wb) begin
                            chk("wb_rw", mem_bus.mem_req_rw, 1'b1);
                            chk("wb_addr", mem_bus.mem_req_addr, victim);
                            chk("wb_data", mem_bus.mem_req_data, gold_line(victim));
                        end else begin
                            chk("fill_rw", mem_bus.mem_req_rw, 1'b0);
                            chk("fill_addr", mem_bus.mem_req_addr, la);
                        end
                        hold_cnt = (mode_hold >= 0) ? mode_hold : $urandom_range(0, 3);
                    end else begin
                        chk("req_stable", {mem_bus.mem_req_rw, mem_bus.mem_req_addr},
                            {req_rw0, req_addr0});
                        if (req_rw0) chk("req_data_stable", mem_bus.mem_req_data, req_data0);
                    end
                    if (hold_cnt == 0) begin
                        mem_bus.mem_req_ready = 1'b1;
                        hs = 1;
                    end else begin
                        hold_cnt--;
                    end
                end
            end
            @(posedge clk); #1;
            mem_bus.mem_req_ready  = 1'b0;
            mem_bus.mem_resp_valid = 1'b0;
            if (hs) begin
                req_open = 0;
                n_req++;
                if (req_rw0) begin
                    for (int w = 0; w < 4; w++) mem_store[{req_addr0, 2'(w)}] = req_data0[32*w +: 32];
                    saw_wb = 1;
                end else begin
                    resp_wait = 1;
                    resp_cnt  = (mode_hold >= 0) ? 0 : $urandom_range(0, 3);
                end
            end
            if (give_resp) resp_wait = 0;
            cycles++;
        end
        chk("done_stall", stall, 1'b0);
        chk("miss", cycles != 0, exp_miss);
        chk("writeback", saw_wb, exp_wb);
        if (mode_hold >= 0)
            chk("latency", cycles, exp_miss ? (3 + mode_hold + (exp_wb ? 1 + mode_hold : 0)) : 0);
        if (!is_store) chk("rdata", dcache_dout, exp_rd);
        if (is_store) begin
            nw = gold_word(wa);
            for (int b = 0; b < 4; b++) if (we[b]) nw[8*b +: 8] = d[8*b +: 8];
            gold[wa] = nw;
        end
        if (exp_miss) begin
            res_valid[idx] = 1;
            res_tag[idx]   = tag;
            res_dirty[idx] = is_store;
        end else if (is_store) begin
            res_dirty[idx] = 1;
        end
    endtask

    bit [23:0]   tag_tbl [5] = '{24'h000000, 24'h000001, 24'h000002, 24'h000003, 24'hABCDEF};
    logic [31:0] ra;
    logic [3:0]  rwe;
    int          kind;
    int          k;

    // Directed scenarios first, then randomized traffic.
    initial begin
        reset       = 1'b1;
        dcache_addr = '0;
        dcache_din  = '0;
        dcache_re   = 1'b0;
        dcache_we   = '0;
        mem_bus.mem_req_ready  = 1'b0;
        mem_bus.mem_resp_valid = 1'b0;
        mem_bus.mem_resp_data  = '0;
        mem_store[30'h40] = 32'hAAAAAAAA;
        mem_store[30'h41] = 32'hBBBBBBBB;
        mem_store[30'h42] = 32'hCCCCCCCC;
        mem_store[30'h43] = 32'hDDDDDDDD;
        foreach (mem_store[i]) gold[i] = mem_store[i];

        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", stall, 1'b0);
        chk("rst_req_valid", mem_bus.mem_req_valid, 1'b0);
        chk("rst_req_rw", mem_bus.mem_req_rw, 1'b0);
        chk("rst_req_addr", mem_bus.mem_req_addr, 28'h0);
        chk("rst_req_data", mem_bus.mem_req_data, 128'h0);
        chk("rst_dout", dcache_dout, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        mode_hold = 0;
        access(32'h100, 32'h0, 4'b0000, 1'b1);
        chk("tp_first_read", dcache_dout, 32'hAAAAAAAA);
        access(32'h104, 32'h0, 4'b0000, 1'b1);
        chk("tp_hit_read", dcache_dout, 32'hBBBBBBBB);
        access(32'h100, 32'h00EF0000, 4'b0100, 1'b0);
        access(32'h100, 32'h0, 4'b0000, 1'b1);
        chk("tp_merged", dcache_dout, 32'hAAEFAAAA);
        access(32'h200, 32'h0, 4'b0000, 1'b1);
        mode_hold = 5;
        access(32'h304, 32'h0, 4'b0000, 1'b1);
        mode_hold = 0;
        dcache_re = 1'b0;
        dcache_we = 4'b0000;

        // Reset while waiting for refill data, then a stray response.
        @(posedge clk); #1;
        dcache_addr = 32'h500;
        dcache_re   = 1'b1;
        @(posedge clk); #1;
        dcache_re = 1'b0;
        k = 0;
        while (!mem_bus.mem_req_valid && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        chk("mid_fill_addr", mem_bus.mem_req_addr, 28'h0000050);
        mem_bus.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_bus.mem_req_ready = 1'b0;
        chk("mid_fill_stall", stall, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_req_valid", mem_bus.mem_req_valid, 1'b0);
        chk("mid_rst_stall", stall, 1'b0);
        mem_bus.mem_resp_valid = 1'b1;
        mem_bus.mem_resp_data  = {4{32'hDEADBEEF}};
        @(posedge clk); #1;
        mem_bus.mem_resp_valid = 1'b0;
        chk("late_resp_stall", stall, 1'b0);
        for (int i = 0; i < 16; i++) begin
            res_valid[i] = 0;
            res_dirty[i] = 0;
        end
        gold.delete();
        foreach (mem_store[i]) gold[i] = mem_store[i];
        access(32'h500, 32'h0, 4'b0000, 1'b1);

        mode_hold = -1;
        repeat (300) begin
            ra   = {tag_tbl[$urandom_range(0, 4)], 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)), 2'b00};
            kind = $urandom_range(0, 2);
            rwe  = (kind == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            access(ra, $urandom, rwe, kind != 1);
            if ($urandom_range(0, 4) == 0) begin
                dcache_re = 1'b0;
                dcache_we = 4'b0000;
                @(posedge clk); #1;
            end
        end
        dcache_re = 1'b0;
        dcache_we = 4'b0000;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache sitting between the stage-3 memory interface and the main-memory port. It accepts word-aligned 32-bit accesses with a 4-bit byte write mask and returns read data one cycle later on a hit. On a miss it raises `stall`, writes back a dirty victim line, refills the line from memory, then completes the held request.

## Interface
- `LINES`, 16: number of cache lines, power of two; `IDX_W = $clog2(LINES)`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  reset, synchronous, active-high.
- `dcache_addr`  in  32  byte address; `[3:2]` word select, `[4+IDX_W-1:4]` index, `[31:4+IDX_W]` tag.
- `dcache_din`  in  32  pre-aligned store data.
- `dcache_re`  in  1  read request.
- `dcache_we`  in  4  byte write mask; any nonzero bit means store.
- `dcache_dout`  out  32  read data (whole word).
- `stall`  out  1  high while the pending request is not yet complete.
- `mem_req_valid`  out  1  memory request valid.
- `mem_req_ready`  in  1  memory accepts the request this cycle.
- `mem_req_rw`  out  1  1 = write line, 0 = read line.
- `mem_req_addr`  out  28  line address (`addr[31:4]`).
- `mem_req_data`  out  128  victim line for writes; word 0 is in bits `[31:0]`.
- `mem_resp_valid`  in  1  refill data valid, one beat.
- `mem_resp_data`  in  128  refill line.

## Operation
- **Request capture:** a request (`dcache_re` or `|dcache_we`) is latched at a posedge when `stall`=0. Store takes priority if both `dcache_re` and `dcache_we` are set. While `stall`=1, inputs are ignored; the core holds them stable.
- **FSM states:**
  - READY: latched request is compared against tag/valid.
    - Hit on read: drive the word.
    - Hit on store: merge bytes per mask and set dirty.
    - Miss: go to WB_REQ if the victim is valid and dirty, else FILL_REQ.
  - WB_REQ: `mem_req_valid`=1, `rw`=1, address = {victim tag, index}, data = victim line. Go to FILL_REQ on `mem_req_ready`.
  - FILL_REQ: `mem_req_valid`=1, `rw`=0, address = request line. Go to FILL_WAIT on `mem_req_ready`.
  - FILL_WAIT: on `mem_resp_valid`, write the line, set valid and the tag, clear dirty, return to READY. The held request then hits.
- **Memory handshake:** `mem_req_valid`, `rw`, `addr` and `data` stay stable until accepted. `mem_resp_valid` outside FILL_WAIT is ignored.
- **Store data:** `dcache_dout` on a store completion is don't-care. Memory always sees whole lines.

## Timing
- **Reset:** all valid and dirty bits clear, FSM READY with no pending request. Outputs after reset: `stall`=0, `mem_req_valid`=0, `mem_req_rw`=0, `mem_req_addr`=0, `mem_req_data`=0, `dcache_dout`=0.
- **Reset mid-miss:** any in-flight memory transaction is abandoned. `mem_req_valid` drops the next cycle; a late `mem_resp_valid` is ignored.
- **Hit latency:** request captured at edge N; `dcache_dout` valid and `stall`=0 in cycle N+1. A new request may be captured at edge N+1, giving back-to-back hits at full throughput.
- **Miss, stall behaviour:** `stall` rises combinationally in cycle N+1 and stays high until the cycle the held request completes in READY.
- **Clean-miss latency:** minimum 1 (compare) + 1 (FILL_REQ with ready) + 1 (FILL_WAIT with resp) + 1 (READY hit) = data at cycle N+4.
- **Dirty miss:** adds ≥1 cycle for WB_REQ.
- **Store hit then load, same word:** the load returns the merged data (no stale read).

## Structure
- **Shared header `dcache.vh`:** state encodings (READY, WB_REQ, FILL_REQ, FILL_WAIT), `LINE_BITS`=128, `OFFSET_BITS`=4, `WORDS_PER_LINE`=4.
- **Sub-module `dcache_line_array`:** holds data, tag, valid and dirty arrays. It provides a combinational read by index, a line write, a byte-masked word write, and a reset clear of valid/dirty. The top level contains the FSM, request latch, hit compare and memory port.

## Test plan
- Reset, then read `0x100` -> `stall` high; FILL_REQ issues `mem_req_addr`=`0x010`, `rw`=0; responding `0x…DDDDCCCCBBBBAAAA` yields `dcache_dout`=`0xAAAAAAAA`, then `stall` low.
- Read `0x104` after that refill -> hit; `dcache_dout`=`0xBBBBBBBB` at N+1, `stall` never asserted.
- Store `dcache_we`=`4'b0100`, `din`=`0x00EF0000` to `0x100`, then read `0x100` -> `0xAAEFAAAA`.
- Read `0x200` (same index, different tag) after that store -> WB_REQ, `rw`=1, `addr`=`0x010`, data word 0 = `0xAAEFAAAA`; then FILL_REQ with `addr`=`0x020`.
- Hold `mem_req_ready`=0 for 5 cycles in FILL_REQ -> `mem_req_valid`/`addr` stable, `stall` held high.
- Assert `reset` during FILL_WAIT, then a spurious `mem_resp_valid` -> no line written; a read of the same address misses again.
